bomb_ctrl: RTL and testbench
============================

// Module: bomb_ctrl
// PURPOSE
//  Bomb lifecycle engine feeding a player controller: consumes the player's bomb_drop request and position, and
//  places a tile-aligned bomb. It runs the fuse, then publishes the blast hazard rectangle
//  (bombX/Y/XS/YS) that the player checks for collisions, and finally enforces a cooldown.
//  One instance per player; all timing is in frame_clk ticks (one per video frame).
// PARAMETERS
//  FUSE_FRAMES     120  ticks from accepted drop to detonation (>=1)
//  BLAST_FRAMES    30   ticks the hazard rectangle is live (>=1)
//  COOL_FRAMES     30   ticks after blast before a new drop is accepted (>=1)
//  TILE            32   grid pitch in pixels; power of two
//  BLAST_R         1    blast radius in tiles around the bomb tile
//  X_MIN/X_MAX     32/575  playfield x bounds, inclusive
//  Y_MIN/Y_MAX     32/447  playfield y bounds, inclusive
//  HALF_X/HALF_Y   10/13   player sprite half-size; centre = pos + half
// PORTS
//  frame_clk  in   1   frame-rate clock
//  Reset      in   1   asynchronous, active-high reset
//  bomb_drop  in   1   drop request level from the player; may stay high for many ticks
//  userX      in   10  player top-left x
//  userY      in   10  player top-left y
//  tileX      out  10  bomb tile top-left x (for the renderer); valid while armed
//  tileY      out  10  bomb tile top-left y; valid while armed
//  armed      out  1   bomb placed, fuse running
//  blast      out  1   explosion active
//  bombX      out  10  hazard rect left; 0 when no hazard
//  bombY      out  10  hazard rect top; 0 when no hazard
//  bombXS     out  10  hazard rect width; 0 when no hazard (0-size never collides)
//  bombYS     out  10  hazard rect height; 0 when no hazard
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, counter=0, drop_q=0, all outputs 0.
//  Drop edge: drop_q registers bomb_drop each tick; edge = bomb_drop & ~drop_q. A held key yields one edge.
//  States: IDLE -> FUSE -> BLAST -> COOL -> IDLE.
//   IDLE: on edge, latch tile, cnt<=FUSE_FRAMES-1, go to FUSE. An edge in any other state is
//     dropped, not queued.
//   FUSE: armed=1, hazard outputs 0. cnt==0 -> BLAST with cnt<=BLAST_FRAMES-1, else cnt--.
//     armed is high for exactly FUSE_FRAMES ticks.
//   BLAST: blast=1 and hazard rect registered for exactly BLAST_FRAMES ticks; then COOL with
//     cnt<=COOL_FRAMES-1.
//   COOL: all outputs 0 for COOL_FRAMES ticks, then IDLE. The first drop is accepted on the
//     tick IDLE is seen.
//  Tile latch (registered on accept tick):
//   cx = userX+HALF_X; tileX = ((cx-X_MIN) & ~(TILE-1)) + X_MIN, clamped to [X_MIN, X_MAX+1-TILE].
//   tileY is formed the same way from userY+HALF_Y.
//  Hazard rect (registered on FUSE->BLAST, held constant through BLAST):
//   L = (tileX < X_MIN+BLAST_R*TILE) ? X_MIN : tileX-BLAST_R*TILE
//   R = min(tileX+(BLAST_R+1)*TILE, X_MAX+1); bombX=L; bombXS=R-L. Y is handled the same way.
//   Compare before subtracting so nothing underflows; all math is 11-bit internally, truncated to 10.
//  BLAST->COOL tick: bombX/Y/XS/YS, blast, tileX/Y all go 0 on the same edge.
//  Player position changes after the drop do not move the bomb.
// TESTING
//  1 Reset, userX=100,userY=200, pulse drop 1 tick -> next tick armed=1, tileX=96, tileY=192.
//    armed stays high 120 ticks.
//  2 Scenario 1 at detonation -> blast=1, bombX=64, bombXS=96, bombY=160, bombYS=96 for 30 ticks.
//    Then all outputs 0.
//  3 userX=32,userY=32 drop -> tile (32,32). On blast: bombX=32, bombXS=64, bombY=32, bombYS=64
//    (clipped at min).
//  4 userX=556,userY=421 drop -> tile (544,416). On blast: bombX=512, bombXS=64, bombY=384, bombYS=64
//    (clipped at max).
//  5 Hold bomb_drop high 400 ticks -> exactly one bomb. Extra edges during FUSE/BLAST/COOL are
//    ignored; an edge on the first IDLE tick is accepted.
//  6 Assert Reset mid-FUSE and mid-BLAST -> outputs 0 immediately (async). A post-reset drop
//    starts a full 120-tick fuse.

Source files
------------

// File: rtl/bomb_ctrl.sv
// bomb_ctrl: per-player bomb lifecycle (IDLE -> FUSE -> BLAST -> COOL).
// Snaps the drop position to the tile grid, times the fuse, then publishes
// a clipped blast hazard rectangle and enforces a cooldown before the next drop.
module bomb_ctrl #(
    parameter int FUSE_FRAMES  = 120,
    parameter int BLAST_FRAMES = 30,
    parameter int COOL_FRAMES  = 30,
    parameter int TILE         = 32,
    parameter int BLAST_R      = 1,
    parameter int X_MIN        = 32,
    parameter int X_MAX        = 575,
    parameter int Y_MIN        = 32,
    parameter int Y_MAX        = 447,
    parameter int HALF_X       = 10,
    parameter int HALF_Y       = 13
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       bomb_drop,
    input  logic [9:0] userX,
    input  logic [9:0] userY,
    output logic [9:0] tileX,
    output logic [9:0] tileY,
    output logic       armed,
    output logic       blast,
    output logic [9:0] bombX,
    output logic [9:0] bombY,
    output logic [9:0] bombXS,
    output logic [9:0] bombYS
);

    localparam int MAXF = (FUSE_FRAMES > BLAST_FRAMES)
                        ? ((FUSE_FRAMES > COOL_FRAMES) ? FUSE_FRAMES : COOL_FRAMES)
                        : ((BLAST_FRAMES > COOL_FRAMES) ? BLAST_FRAMES : COOL_FRAMES);
    localparam int CW = (MAXF > 1) ? $clog2(MAXF) : 1;

    localparam logic [CW-1:0] FUSE_LD  = CW'(FUSE_FRAMES - 1);
    localparam logic [CW-1:0] BLAST_LD = CW'(BLAST_FRAMES - 1);
    localparam logic [CW-1:0] COOL_LD  = CW'(COOL_FRAMES - 1);

    // All geometry is done in 11 bits so the +half / +reach sums cannot wrap.
    localparam logic [10:0] TSZ   = 11'(TILE);
    localparam logic [10:0] TMASK = ~(11'(TILE - 1));
    localparam logic [10:0] REACH = 11'(BLAST_R * TILE);
    localparam logic [10:0] XLO   = 11'(X_MIN);
    localparam logic [10:0] XHI1  = 11'(X_MAX + 1);
    localparam logic [10:0] YLO   = 11'(Y_MIN);
    localparam logic [10:0] YHI1  = 11'(Y_MAX + 1);
    localparam logic [10:0] HX    = 11'(HALF_X);
    localparam logic [10:0] HY    = 11'(HALF_Y);

    typedef enum logic [1:0] {IDLE, FUSE, BLAST, COOL} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          drop_q, drop_edge;
    logic [9:0]    tile_x_n, tile_y_n;
    logic [9:0]    bomb_x_n, bomb_y_n, bomb_xs_n, bomb_ys_n;

    // Sprite centre snapped to the grid relative to the playfield origin,
    // kept fully inside the playfield. Centres left of the field pin to lo.
    function automatic logic [10:0] snap(input logic [9:0] pos, input logic [10:0] half,
                                         input logic [10:0] lo, input logic [10:0] hi1);
        logic [10:0] c, t;
        c = {1'b0, pos} + half;
        if (c < lo) t = lo;
        else        t = ((c - lo) & TMASK) + lo;
        if (t > hi1 - TSZ) t = hi1 - TSZ;
        return t;
    endfunction

    // Near edge of the blast; compared before subtracting to avoid underflow.
    function automatic logic [10:0] span_lo(input logic [9:0] tile, input logic [10:0] lo);
        logic [10:0] t;
        t = {1'b0, tile};
        return (t < lo + REACH) ? lo : t - REACH;
    endfunction

    // Blast extent, far edge clipped to one past the playfield maximum.
    function automatic logic [10:0] span_size(input logic [9:0] tile, input logic [10:0] lo,
                                              input logic [10:0] hi1);
        logic [10:0] r;
        r = {1'b0, tile} + REACH + TSZ;
        if (r > hi1) r = hi1;
        return r - span_lo(tile, lo);
    endfunction

    // A held key produces a single accept opportunity.
    assign drop_edge = bomb_drop & ~drop_q;
    assign armed     = (state == FUSE);
    assign blast     = (state == BLAST);

    // Next-state, countdown and geometry latching.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        tile_x_n  = tileX;
        tile_y_n  = tileY;
        bomb_x_n  = bombX;
        bomb_y_n  = bombY;
        bomb_xs_n = bombXS;
        bomb_ys_n = bombYS;
        case (state)
            IDLE: begin
                if (drop_edge) begin
                    state_n  = FUSE;
                    cnt_n    = FUSE_LD;
                    tile_x_n = 10'(snap(userX, HX, XLO, XHI1));
                    tile_y_n = 10'(snap(userY, HY, YLO, YHI1));
                end
            end
            FUSE: begin
                if (cnt == '0) begin
                    state_n   = BLAST;
                    cnt_n     = BLAST_LD;
                    bomb_x_n  = 10'(span_lo(tileX, XLO));
                    bomb_y_n  = 10'(span_lo(tileY, YLO));
                    bomb_xs_n = 10'(span_size(tileX, XLO, XHI1));
                    bomb_ys_n = 10'(span_size(tileY, YLO, YHI1));
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            BLAST: begin
                if (cnt == '0) begin
                    state_n   = COOL;
                    cnt_n     = COOL_LD;
                    tile_x_n  = '0;
                    tile_y_n  = '0;
                    bomb_x_n  = '0;
                    bomb_y_n  = '0;
                    bomb_xs_n = '0;
                    bomb_ys_n = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            COOL: begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - CW'(1);
            end
        endcase
    end

    // State, counter, drop history and output registers.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            cnt    <= '0;
            drop_q <= 1'b0;
            tileX  <= '0;
            tileY  <= '0;
            bombX  <= '0;
            bombY  <= '0;
            bombXS <= '0;
            bombYS <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            drop_q <= bomb_drop;
            tileX  <= tile_x_n;
            tileY  <= tile_y_n;
            bombX  <= bomb_x_n;
            bombY  <= bomb_y_n;
            bombXS <= bomb_xs_n;
            bombYS <= bomb_ys_n;
        end
    end

endmodule

// File: tb/tb_bomb_ctrl.sv
// tb_bomb_ctrl: randomized and directed checks of bomb_ctrl against a
// timeline model (accept tick + elapsed ticks) with integer geometry.
module tb_bomb_ctrl;

    localparam int F = 120;
    localparam int B = 30;
    localparam int C = 30;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       bomb_drop;
    logic [9:0] userX, userY;
    logic [9:0] tileX, tileY, bombX, bombY, bombXS, bombYS;
    logic       armed, blast;

    bomb_ctrl dut (
        .frame_clk(frame_clk), .Reset(Reset), .bomb_drop(bomb_drop),
        .userX(userX), .userY(userY), .tileX(tileX), .tileY(tileY),
        .armed(armed), .blast(blast), .bombX(bombX), .bombY(bombY),
        .bombXS(bombXS), .bombYS(bombYS)
    );

    initial forever #5 frame_clk = ~frame_clk;

    int vectors = 0;
    int miscompares = 0;
    int tick = 0;
    int acc = 0;
    bit have = 0;
    bit prev = 0;
    int etx = 0, ety = 0;

    // Reference geometry: grid snap by integer division, then clip.
    function automatic int snap_ref(int p, int half, int lo, int hi);
        int c, t;
        c = p + half;
        if (c < lo) t = lo;
        else        t = lo + ((c - lo) / 32) * 32;
        if (t > hi + 1 - 32) t = hi + 1 - 32;
        return t;
    endfunction

    function automatic int lo_ref(int t, int lo);
        return (t - 32 < lo) ? lo : t - 32;
    endfunction

    function automatic int size_ref(int t, int lo, int hi);
        int r;
        r = t + 64;
        if (r > hi + 1) r = hi + 1;
        return r - lo_ref(t, lo);
    endfunction

    // Expected outputs from the time elapsed since the last accepted drop.
    function automatic logic [61:0] expv();
        int rel;
        logic [61:0] v;
        v = '0;
        if (have) begin
            rel = tick - acc;
            if (rel < F)
                v = {2'b10, 10'(etx), 10'(ety), 40'd0};
            else if (rel < F + B)
                v = {2'b01, 10'(etx), 10'(ety), 10'(lo_ref(etx, 32)), 10'(lo_ref(ety, 32)),
                     10'(size_ref(etx, 32, 575)), 10'(size_ref(ety, 32, 447))};
        end
        return v;
    endfunction

    function automatic logic [61:0] obsv();
        return {armed, blast, tileX, tileY, bombX, bombY, bombXS, bombYS};
    endfunction

    // One frame: drive, clock, advance the model, settle.
    task automatic step(input bit d, input int x, input int y);
        @(negedge frame_clk);
        bomb_drop = d;
        userX = 10'(x);
        userY = 10'(y);
        @(posedge frame_clk);
        tick++;
        if (d && !prev && (!have || tick - acc > F + B + C)) begin
            have = 1;
            acc  = tick;
            etx  = snap_ref(x, 10, 32, 575);
            ety  = snap_ref(y, 13, 32, 447);
        end
        prev = d;
        #1;
    endtask

    task automatic model_reset();
        have = 0;
        prev = 0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bomb_drop = 1'b0;
        userX = '0;
        userY = '0;
        model_reset();
        repeat (2) @(posedge frame_clk);
        #1;
        vectors++;
        if (obsv() !== 62'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h want 0", obsv());
        end
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic test_center();
        int na, nb;
        step(1, 100, 200);
        vectors++;
        if ({armed, tileX, tileY} !== {1'b1, 10'd96, 10'd192}) begin
            miscompares++;
            $display("FAIL center_tile: got a=%b %0d,%0d want a=1 96,192", armed, tileX, tileY);
        end
        na = 1; nb = 0;
        for (int i = 0; i < 185; i++) begin
            step(0, $urandom_range(0, 1023), $urandom_range(0, 1023));
            na += armed; nb += blast;
            vectors++;
            if (obsv() !== expv()) begin
                miscompares++;
                $display("FAIL center_seq t=%0d: got %h want %h", tick - acc, obsv(), expv());
            end
            if (tick - acc == F) begin
                vectors++;
                if ({blast, bombX, bombXS, bombY, bombYS} !== {1'b1, 10'd64, 10'd96, 10'd160, 10'd96}) begin
                    miscompares++;
                    $display("FAIL center_rect: got %0d %0d %0d %0d want 64 96 160 96",
                             bombX, bombXS, bombY, bombYS);
                end
            end
        end
        vectors++;
        if (na != F || nb != B) begin
            miscompares++;
            $display("FAIL center_durations: got armed=%0d blast=%0d want %0d %0d", na, nb, F, B);
        end
    endtask

    task automatic test_clip(input string name, input int x, input int y, input int ex, input int ey,
                             input int bx, input int bxs, input int by, input int bys);
        step(1, x, y);
        vectors++;
        if ({tileX, tileY} !== {10'(ex), 10'(ey)}) begin
            miscompares++;
            $display("FAIL %s_tile: got %0d,%0d want %0d,%0d", name, tileX, tileY, ex, ey);
        end
        for (int i = 0; i < F + B + C; i++) begin
            step(0, x, y);
            vectors++;
            if (obsv() !== expv()) begin
                miscompares++;
                $display("FAIL %s_seq t=%0d: got %h want %h", name, tick - acc, obsv(), expv());
            end
            if (tick - acc == F) begin
                vectors++;
                if ({bombX, bombXS, bombY, bombYS} !== {10'(bx), 10'(bxs), 10'(by), 10'(bys)}) begin
                    miscompares++;
                    $display("FAIL %s_rect: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                             name, bombX, bombXS, bombY, bombYS, bx, bxs, by, bys);
                end
            end
        end
    endtask

    task automatic test_hold();
        int bombs;
        bit last;
        bombs = 0; last = 0;
        for (int i = 0; i < 400; i++) begin
            step(1, 250, 250);
            if (armed && !last) bombs++;
            last = armed;
            vectors++;
            if (obsv() !== expv()) begin
                miscompares++;
                $display("FAIL hold_seq i=%0d: got %h want %h", i, obsv(), expv());
            end
        end
        vectors++;
        if (bombs != 1) begin
            miscompares++;
            $display("FAIL hold_count: got %0d bombs want 1", bombs);
        end
        step(0, 250, 250);
    endtask

    task automatic test_first_idle();
        step(1, 300, 100);
        for (int i = 0; i < F + B + C - 1; i++) step(0, 300, 100);
        step(1, 300, 100);
        vectors++;
        if (armed !== 1'b0) begin
            miscompares++;
            $display("FAIL cool_edge_drop: got armed=%b want 0", armed);
        end
        step(0, 300, 100);
        step(1, 400, 300);
        vectors++;
        if (obsv() !== expv() || armed !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_accept: got %h want %h", obsv(), expv());
        end
        for (int i = 0; i < F + B + C; i++) step(0, 400, 300);
        step(1, 64, 64);
        vectors++;
        if (obsv() !== expv() || armed !== 1'b1) begin
            miscompares++;
            $display("FAIL first_idle_tick: got %h want %h", obsv(), expv());
        end
        for (int i = 0; i < F + B + C; i++) begin
            step(0, 64, 64);
            vectors++;
            if (obsv() !== expv()) begin
                miscompares++;
                $display("FAIL first_idle_seq t=%0d: got %h want %h", tick - acc, obsv(), expv());
            end
        end
    endtask

    task automatic async_hit(input string name);
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (obsv() !== 62'd0) begin
            miscompares++;
            $display("FAIL %s: got %h want 0", name, obsv());
        end
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic test_async_reset();
        int na;
        step(1, 200, 200);
        for (int i = 0; i < 49; i++) step(0, 200, 200);
        async_hit("reset_mid_fuse");
        step(1, 300, 300);
        for (int i = 0; i < 129; i++) step(0, 300, 300);
        vectors++;
        if (blast !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_blast: got blast=%b want 1", blast);
        end
        async_hit("reset_mid_blast");
        step(1, 150, 350);
        na = armed;
        for (int i = 0; i < F + B + C; i++) begin
            step(0, 150, 350);
            na += armed;
            vectors++;
            if (obsv() !== expv()) begin
                miscompares++;
                $display("FAIL post_reset_seq t=%0d: got %h want %h", tick - acc, obsv(), expv());
            end
        end
        vectors++;
        if (na != F) begin
            miscompares++;
            $display("FAIL post_reset_fuse: got %0d armed ticks want %0d", na, F);
        end
    endtask

    task automatic test_random();
        bit d;
        int x, y;
        d = 0;
        x = $urandom_range(0, 1023);
        y = $urandom_range(0, 1023);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) d = ~d;
            if ($urandom_range(0, 7) == 0) begin
                x = $urandom_range(0, 1023);
                y = $urandom_range(0, 1023);
            end
            step(d, x, y);
            vectors++;
            if (obsv() !== expv()) begin
                miscompares++;
                $display("FAIL random i=%0d: got %h want %h", i, obsv(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_center();
        test_clip("clip_min", 32, 32, 32, 32, 32, 64, 32, 64);
        test_clip("clip_max", 556, 421, 544, 416, 512, 64, 384, 64);
        test_hold();
        test_first_idle();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
